// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: redirect kind encodings and pc_gen FSM states.
package riscv_pkg;

  localparam logic [1:0] REDIR_BR   = 2'b00;
  localparam logic [1:0] REDIR_JAL  = 2'b01;
  localparam logic [1:0] REDIR_JALR = 2'b10;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'b00,
    PCG_RUN  = 2'b01,
    PCG_PEND = 2'b10
  } pcg_state_e;

  // Encoding 2'b11 is reserved and must never cause a redirect.
  function automatic logic redir_kind_valid(input logic [1:0] kind);
    return (kind == REDIR_BR) || (kind == REDIR_JAL) || (kind == REDIR_JALR);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: base + imm (wrapping), jalr clears bit 0,
// plus a flag for targets that are not 4-byte aligned.
module pc_target_calc
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      kind_i,
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] sum;

  always_comb begin
    sum = base_i + imm_i;
    if (kind_i == REDIR_JALR) begin
      sum[0] = 1'b0;
    end
    target_o     = sum;
    misaligned_o = |sum[1:0];
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator for fetch: valid/ready handshake, stall hold, prioritised
// trap/redirect with buffering under back-pressure. Optional macro: PC_MISALIGN_EN.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
  parameter int unsigned     ILEN     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic            redir_vld_i,
  input  logic [1:0]      redir_kind_i,
  input  logic [XLEN-1:0] redir_base_i,
  input  logic [XLEN-1:0] redir_imm_i,
  input  logic            pc_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_vld_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            flush_o,
  output logic            misalign_o
);

`ifdef PC_MISALIGN_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  pcg_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pc_vld_q, pc_vld_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] calc_target;
  logic            calc_misaligned;
  logic            redir_take;
  logic            take;
  logic            mis_hit;
  logic [XLEN-1:0] target;

  pc_target_calc #(.XLEN(XLEN)) u_target_calc (
    .kind_i       (redir_kind_i),
    .base_i       (redir_base_i),
    .imm_i        (redir_imm_i),
    .target_o     (calc_target),
    .misaligned_o (calc_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;

    redir_take = redir_vld_i && redir_kind_valid(redir_kind_i);
    take       = trap_i || redir_take;
    // A trap outranks the redirect, so a misaligned redirect alongside it is moot.
    mis_hit    = MISALIGN_EN && !trap_i && redir_take && calc_misaligned;
    target     = (trap_i || mis_hit) ? TRAP_VEC : calc_target;

    case (state_q)
      PCG_BOOT: begin
        state_d = PCG_RUN;
      end
      PCG_RUN: begin
        if (take) begin
          flush_d    = 1'b1;
          misalign_d = mis_hit;
          if (pc_ready_i) begin
            pc_d = target;
          end else begin
            pend_pc_d = target;
            state_d   = PCG_PEND;
          end
        end else if (!stall_i && pc_ready_i) begin
          pc_d = pc_q + XLEN'(ILEN);
        end
      end
      PCG_PEND: begin
        // Newest redirect wins; pc_o stays put until fetch accepts it.
        if (take) begin
          flush_d    = 1'b1;
          misalign_d = mis_hit;
          if (pc_ready_i) begin
            pc_d    = target;
            state_d = PCG_RUN;
          end else begin
            pend_pc_d = target;
          end
        end else if (pc_ready_i) begin
          pc_d    = pend_pc_q;
          state_d = PCG_RUN;
        end
      end
      default: begin
        state_d = PCG_BOOT;
      end
    endcase

    pc_vld_d = (state_d != PCG_BOOT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PCG_BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      pc_vld_q   <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pc_vld_q   <= pc_vld_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_vld_o   = pc_vld_q;
  assign pc_plus_o  = pc_q + XLEN'(ILEN);
  assign flush_o    = flush_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed vectors push hand-computed expectations,
// a monitor pops and compares them one cycle later.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        trap_i;
  logic        redir_vld_i;
  logic [1:0]  redir_kind_i;
  logic [31:0] redir_base_i;
  logic [31:0] redir_imm_i;
  logic        pc_ready_i;
  logic [31:0] pc_o;
  logic        pc_vld_o;
  logic [31:0] pc_plus_o;
  logic        flush_o;
  logic        misalign_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus;
    logic        vld;
    logic        flush;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   vectors  = 0;
  int   failures = 0;

`ifdef PC_MISALIGN_EN
  localparam logic [31:0] JALR_EXP = 32'h0000_0100;
  localparam logic        JALR_MIS = 1'b1;
  localparam logic [31:0] JAL6_EXP = 32'h0000_0100;
  localparam logic        JAL6_MIS = 1'b1;
`else
  localparam logic [31:0] JALR_EXP = 32'h0000_0102;
  localparam logic        JALR_MIS = 1'b0;
  localparam logic [31:0] JAL6_EXP = 32'h0000_0006;
  localparam logic        JAL6_MIS = 1'b0;
`endif

  pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .trap_i       (trap_i),
    .redir_vld_i  (redir_vld_i),
    .redir_kind_i (redir_kind_i),
    .redir_base_i (redir_base_i),
    .redir_imm_i  (redir_imm_i),
    .pc_ready_i   (pc_ready_i),
    .pc_o         (pc_o),
    .pc_vld_o     (pc_vld_o),
    .pc_plus_o    (pc_plus_o),
    .flush_o      (flush_o),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue what the DUT
  // must show after the following rising edge.
  task automatic applyStimulus(
    input logic        rst_v,
    input logic        stall_v,
    input logic        trap_v,
    input logic        rvld_v,
    input logic [1:0]  kind_v,
    input logic [31:0] base_v,
    input logic [31:0] imm_v,
    input logic        ready_v,
    input logic [31:0] e_pc,
    input logic        e_vld,
    input logic        e_flush,
    input logic        e_mis
  );
    exp_t e;
    rst          = rst_v;
    stall_i      = stall_v;
    trap_i       = trap_v;
    redir_vld_i  = rvld_v;
    redir_kind_i = kind_v;
    redir_base_i = base_v;
    redir_imm_i  = imm_v;
    pc_ready_i   = ready_v;
    e.pc    = e_pc;
    e.plus  = e_pc + 32'd4;
    e.vld   = e_vld;
    e.flush = e_flush;
    e.mis   = e_mis;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (pc_o !== e.pc || pc_plus_o !== e.plus || pc_vld_o !== e.vld ||
        flush_o !== e.flush || misalign_o !== e.mis) begin
      failures++;
      $display("[TB] FAIL vec%0d: got pc=%h plus=%h vld=%b flush=%b mis=%b, want pc=%h plus=%h vld=%b flush=%b mis=%b",
               vectors, pc_o, pc_plus_o, pc_vld_o, flush_o, misalign_o,
               e.pc, e.plus, e.vld, e.flush, e.mis);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    rst          = 1'b0;
    stall_i      = 1'b0;
    trap_i       = 1'b0;
    redir_vld_i  = 1'b0;
    redir_kind_i = 2'b00;
    redir_base_i = '0;
    redir_imm_i  = '0;
    pc_ready_i   = 1'b1;
    @(negedge clk);

    //            rst stl trp rvl kind   base           imm            rdy  pc             vld  fl   mis
    // reset, boot, sequential fetch
    applyStimulus(0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0000, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0000, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0004, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0008, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_000C, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0010, 1, 0, 0);
    // stall hold and release
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0010, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0010, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0010, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0014, 1, 0, 0);
    // branch with negative offset, jalr bit-0 clear, jalr wrap
    applyStimulus(1, 0, 0, 1, 2'b00, 32'h20,       32'hFFFF_FFF0, 1, 32'h0000_0010, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0014, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 2'b10, 32'h103,      32'h0,        1, JALR_EXP,      1, 1, JALR_MIS);
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, JALR_EXP,      1, 0, 0);
    applyStimulus(1, 0, 0, 1, 2'b10, 32'hFFFF_FFFC, 32'h8,       1, 32'h0000_0004, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0004, 1, 0, 0);
    // back-pressured jal, trap overwrites pending, stall ignored on acceptance
    applyStimulus(1, 0, 0, 1, 2'b01, 32'h70,       32'h10,       0, 32'h0000_0004, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0004, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        0, 32'h0000_0004, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0100, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0104, 1, 0, 0);
    // trap beats a simultaneous jal to 0x40
    applyStimulus(1, 0, 1, 1, 2'b01, 32'h40,       32'h0,        1, 32'h0000_0100, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0104, 1, 0, 0);
    // redirect beats a simultaneous stall
    applyStimulus(1, 1, 0, 1, 2'b00, 32'h200,      32'h20,       1, 32'h0000_0220, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0220, 1, 0, 0);
    // reserved kind is not a redirect
    applyStimulus(1, 0, 0, 1, 2'b11, 32'h500,      32'h0,        1, 32'h0000_0224, 1, 0, 0);
    // misaligned jal target
    applyStimulus(1, 0, 0, 1, 2'b01, 32'h0,        32'h6,        1, JAL6_EXP,      1, 1, JAL6_MIS);
    applyStimulus(1, 1, 0, 0, 2'b00, 32'h0,        32'h0,        1, JAL6_EXP,      1, 0, 0);
    // reset while pending discards the buffered target
    applyStimulus(1, 0, 0, 1, 2'b01, 32'h300,      32'h0,        0, JAL6_EXP,      1, 1, 0);
    applyStimulus(0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0000, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0000, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0004, 1, 0, 0);
    // link value and sequential fetch wrap at the top of the address space
    applyStimulus(1, 0, 0, 1, 2'b10, 32'hFFFF_FFF0, 32'hC,       1, 32'hFFFF_FFFC, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 2'b00, 32'h0,        32'h0,        1, 32'h0000_0000, 1, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
